// File: rtl/min_uint16_seq_if.sv
// Operand/result handshake bundle for the bit-serial minimum unit.
// The slave side is the compute block; the master side is the feeder/consumer.
interface min_uint16_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             a_le_b;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Y, a_le_b
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Y, a_le_b
  );
endinterface

// File: rtl/min_uint16_seq.sv
// Bit-serial unsigned minimum: compares one operand pair MSB-first, one bit per
// cycle, and returns min(A,B) plus an A-selected flag over a valid/ready handshake.
module min_uint16_seq #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  min_uint16_seq_if.slave  bus,
  output logic             busy
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             sel_q, sel_d;
  logic             dec_q, dec_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             a_le_b_q, a_le_b_d;

  logic bit_a, bit_b, diff;

  assign bit_a = ra_q[idx_q];
  assign bit_b = rb_q[idx_q];
  assign diff  = bit_a ^ bit_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      idx_q    <= '0;
      sel_q    <= 1'b0;
      dec_q    <= 1'b0;
      y_q      <= '0;
      a_le_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      dec_q    <= dec_d;
      y_q      <= y_d;
      a_le_b_q <= a_le_b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    idx_d    = idx_q;
    sel_d    = sel_q;
    dec_d    = dec_q;
    y_d      = y_q;
    a_le_b_d = a_le_b_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          ra_d    = bus.A;
          rb_d    = bus.B;
          idx_d   = IW'(WIDTH - 1);
          dec_d   = 1'b0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        // The smaller operand is the one holding 0 at the highest differing bit.
        if (!dec_q && diff) begin
          sel_d = ~bit_a;
          dec_d = 1'b1;
        end
        if ((EARLY_EXIT && diff) || (idx_q == '0)) begin
          if (!dec_q && !diff) sel_d = 1'b1;
          y_d      = sel_d ? ra_q : rb_q;
          a_le_b_d = sel_d;
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gate with rst so the feeder sees no ready while reset is held.
  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.Y         = y_q;
  assign bus.a_le_b    = a_le_b_q;
  assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_min_uint16_seq.sv
// Bench for min_uint16_seq: directed vector table, reset-abort sequence and
// randomized pairs against a reference model, for both exit modes.
module tb_min_uint16_seq;
  logic clk;
  logic rst;

  // Index 0: early-exit instance, index 1: full-width instance.
  logic        in_valid  [2];
  logic [15:0] a_in      [2];
  logic [15:0] b_in      [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [15:0] y_out     [2];
  logic        sel_out   [2];
  logic        busy      [2];
  logic        busy0, busy1;

  int checks = 0;
  int errors = 0;

  min_uint16_seq_if #(.WIDTH(16)) if0 ();
  min_uint16_seq_if #(.WIDTH(16)) if1 ();

  min_uint16_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave), .busy (busy0)
  );
  min_uint16_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave), .busy (busy1)
  );

  assign if0.in_valid  = in_valid[0];
  assign if0.A         = a_in[0];
  assign if0.B         = b_in[0];
  assign if0.out_ready = out_ready[0];
  assign if1.in_valid  = in_valid[1];
  assign if1.A         = a_in[1];
  assign if1.B         = b_in[1];
  assign if1.out_ready = out_ready[1];
  assign in_ready[0]   = if0.in_ready;
  assign out_valid[0]  = if0.out_valid;
  assign y_out[0]      = if0.Y;
  assign sel_out[0]    = if0.a_le_b;
  assign in_ready[1]   = if1.in_ready;
  assign out_valid[1]  = if1.out_valid;
  assign y_out[1]      = if1.Y;
  assign sel_out[1]    = if1.a_le_b;
  assign busy[0]       = busy0;
  assign busy[1]       = busy1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic        sel;
    int          k;
    int          hold;
    bit          inject;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: number of compare cycles from the position of the top differing bit.
  function automatic int ref_k(input int d, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    x = a ^ b;
    if (d == 1 || x == 16'h0) return 16;
    for (int i = 15; i >= 0; i--)
      if (x[i]) return 16 - i;
    return 16;
  endfunction

  task automatic txn(input int d, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] ey, input logic es, input int ek,
                     input int hold, input bit inject);
    int          cnt;
    logic [15:0] y0;
    logic        s0;
    @(negedge clk);
    in_valid[d]  = 1'b1;
    a_in[d]      = a;
    b_in[d]      = b;
    out_ready[d] = 1'b0;
    chk("in_ready_idle", 32'(in_ready[d]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    cnt = 0;
    while (!out_valid[d] && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("latency", 32'(cnt), 32'(ek));
    if (!out_valid[d]) begin
      chk("out_valid_timeout", 32'(out_valid[d]), 32'd1);
      return;
    end
    chk("y", 32'(y_out[d]), 32'(ey));
    chk("a_le_b", 32'(sel_out[d]), 32'(es));
    y0 = y_out[d];
    s0 = sel_out[d];
    for (int h = 0; h < hold; h++) begin
      if (inject && h == 1) begin
        in_valid[d] = 1'b1;
        a_in[d]     = 16'h0000;
        b_in[d]     = 16'h0001;
      end
      if (inject && h == 2) in_valid[d] = 1'b0;
      chk("hold_stable", {14'd0, out_valid[d], sel_out[d], y_out[d]}, {14'd0, 1'b1, s0, y0});
      chk("hold_in_ready", {30'd0, in_ready[d], busy[d]}, {30'd0, 1'b0, 1'b1});
      @(posedge clk);
      #1;
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    chk("post_hs", {29'd0, out_valid[d], in_ready[d], busy[d]}, {29'd0, 1'b0, 1'b1, 1'b0});
    chk("y_keeps", 32'(y_out[d]), 32'(y0));
    if (inject) begin
      @(posedge clk);
      #1;
      chk("inject_not_taken", 32'(busy[d]), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb, ey;
    logic        es;
    int          mode;

    tbl[0] = '{0, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0,  1, 0, 1'b0};
    tbl[1] = '{0, 16'h1234, 16'h1235, 16'h1234, 1'b1, 16, 0, 1'b0};
    tbl[2] = '{0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b1, 16, 0, 1'b0};
    tbl[3] = '{0, 16'h00FF, 16'h0100, 16'h00FF, 1'b1,  8, 5, 1'b1};
    tbl[4] = '{1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 16, 0, 1'b0};
    tbl[5] = '{1, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0, 16, 2, 1'b0};
    tbl[6] = '{0, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16, 1, 1'b0};
    tbl[7] = '{1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b1, 16, 0, 1'b0};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      a_in[d]      = 16'h0;
      b_in[d]      = 16'h0;
      out_ready[d] = 1'b0;
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_outputs", {28'd0, out_valid[d], in_ready[d], busy[d], sel_out[d]}, 32'd0);
      chk("rst_y", 32'(y_out[d]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i])
      txn(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].sel, tbl[i].k, tbl[i].hold, tbl[i].inject);

    // Reset asserted mid-compare must abort cleanly.
    @(negedge clk);
    in_valid[0] = 1'b1;
    a_in[0]     = 16'h1234;
    b_in[0]     = 16'h1235;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("busy_before_rst", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_abort", {29'd0, out_valid[0], busy[0], in_ready[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk("no_stale", {30'd0, out_valid[0], busy[0]}, 32'd0);
    end
    txn(0, 16'd5, 16'd3, 16'd3, 1'b0, 14, 0, 1'b0);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 1000; n++) begin
        ra   = 16'($urandom);
        mode = int'($urandom_range(0, 3));
        case (mode)
          0:       rb = 16'($urandom);
          1:       rb = ra;
          2:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
          default: rb = ra ^ 16'($urandom_range(0, 255));
        endcase
        ey = (ra <= rb) ? ra : rb;
        es = (ra <= rb);
        txn(d, ra, rb, ey, es, ref_k(d, ra, rb), int'($urandom_range(0, 2)), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
